// File: rtl/head_table_rd_stage.sv
// Head-table read stage: looks up a bucket's head pointer and merges it into the task.
// Credit counting guarantees a free output slot for every RAM read that is in flight.
package hash_table;
  localparam int BUCKET_WIDTH     = 8;
  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int KEY_WIDTH        = 16;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_ptr_val;
  } ht_pdata_t;
endpackage

module head_table_rd_stage #(
  parameter int RAM_LATENCY  = 2,
  parameter int BUCKET_WIDTH = hash_table::BUCKET_WIDTH,
  parameter int A_WIDTH      = hash_table::TABLE_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = RAM_LATENCY + 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  hash_table::ht_pdata_t task_i,
  input  logic                  task_valid_i,
  output logic                  task_ready_o,
  output logic [BUCKET_WIDTH-1:0] ht_rd_addr_o,
  output logic                  ht_rd_en_o,
  input  logic [A_WIDTH:0]      ht_rd_data_i,
  output hash_table::ht_pdata_t task_o,
  output logic                  task_valid_o,
  input  logic                  task_ready_i,
  output logic                  busy_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] P_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  logic [CW-1:0]          r_cnt;
  logic [RAM_LATENCY-1:0] r_sr_vld;
  hash_table::ht_pdata_t  r_sr_task [RAM_LATENCY];
  hash_table::ht_pdata_t  r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_mem_cnt;
  hash_table::ht_pdata_t  r_out;
  logic                   r_out_vld;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_load;
  logic                  w_mem_empty;
  logic                  w_bypass;
  logic                  w_mem_push;
  logic                  w_mem_pop;
  hash_table::ht_pdata_t w_wr_task;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + P_ONE;
  endfunction

  assign task_ready_o = (r_cnt < C_DEPTH);
  assign w_accept     = task_valid_i && task_ready_o;
  assign w_pop        = r_out_vld && task_ready_i;
  assign ht_rd_en_o   = w_accept;
  assign ht_rd_addr_o = w_accept ? task_i.bucket : '0;
  assign busy_o       = (r_cnt != '0);
  assign task_o       = r_out;
  assign task_valid_o = r_out_vld;

  always_comb begin
    w_wr_task              = r_sr_task[RAM_LATENCY-1];
    w_wr_task.head_ptr     = ht_rd_data_i[A_WIDTH-1:0];
    w_wr_task.head_ptr_val = ht_rd_data_i[A_WIDTH];
  end

  // The output register is the head of the FIFO; r_mem holds the entries behind it.
  assign w_wr        = r_sr_vld[RAM_LATENCY-1];
  assign w_load      = !r_out_vld || w_pop;
  assign w_mem_empty = (r_mem_cnt == '0);
  assign w_bypass    = w_wr && w_load && w_mem_empty;
  assign w_mem_push  = w_wr && !w_bypass;
  assign w_mem_pop   = w_load && !w_mem_empty;

  // Task payloads need no reset: every consumer is qualified by a cleared valid.
  always_ff @(posedge clk_i) begin
    r_sr_task[0] <= task_i;
    for (int i = 1; i < RAM_LATENCY; i++) r_sr_task[i] <= r_sr_task[i-1];
    if (w_mem_push) r_mem[r_wr_ptr] <= w_wr_task;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sr_vld  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sr_vld[0] <= w_accept;
      for (int i = 1; i < RAM_LATENCY; i++) r_sr_vld[i] <= r_sr_vld[i-1];

      if (w_mem_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_mem_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      if (w_mem_push && !w_mem_pop)      r_mem_cnt <= r_mem_cnt + C_ONE;
      else if (!w_mem_push && w_mem_pop) r_mem_cnt <= r_mem_cnt - C_ONE;

      if (w_load) begin
        if (!w_mem_empty) begin
          r_out     <= r_mem[r_rd_ptr];
          r_out_vld <= 1'b1;
        end else if (w_wr) begin
          r_out     <= w_wr_task;
          r_out_vld <= 1'b1;
        end else begin
          r_out_vld <= 1'b0;
        end
      end

      if (w_accept && !w_pop)      r_cnt <= r_cnt + C_ONE;
      else if (!w_accept && w_pop) r_cnt <= r_cnt - C_ONE;
    end
  end
endmodule

// File: tb/tb_head_table_rd_stage.sv
// Bench for head_table_rd_stage: directed vectors plus a queue-based reference model.
`timescale 1ns/1ps
module tb_head_table_rd_stage;
  localparam int L     = 2;
  localparam int DEPTH = L + 2;
  localparam int BW    = 8;
  localparam int AW    = 8;
  typedef hash_table::ht_pdata_t task_t;

  logic          clk = 1'b0;
  logic          rst;
  task_t         task_i;
  logic          task_valid_i;
  logic          task_ready_o;
  logic [BW-1:0] ht_rd_addr_o;
  logic          ht_rd_en_o;
  logic [AW:0]   ht_rd_data_i;
  task_t         task_o;
  logic          task_valid_o;
  logic          task_ready_i;
  logic          busy_o;

  always #5 clk = ~clk;

  head_table_rd_stage #(.RAM_LATENCY(L), .BUCKET_WIDTH(BW), .A_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .task_i(task_i), .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
    .ht_rd_addr_o(ht_rd_addr_o), .ht_rd_en_o(ht_rd_en_o), .ht_rd_data_i(ht_rd_data_i),
    .task_o(task_o), .task_valid_o(task_valid_o), .task_ready_i(task_ready_i),
    .busy_o(busy_o)
  );

  // Head-table RAM: fixed latency, not reset, returns junk when no read is due.
  logic [AW:0]   ht_mem [256];
  logic [BW-1:0] d_addr [L];
  logic          d_en   [L];
  always @(posedge clk) begin
    d_en[0]   <= ht_rd_en_o;
    d_addr[0] <= ht_rd_addr_o;
    for (int i = 1; i < L; i++) begin
      d_en[i]   <= d_en[i-1];
      d_addr[i] <= d_addr[i-1];
    end
  end
  assign ht_rd_data_i = d_en[L-1] ? ht_mem[d_addr[L-1]] : {(AW+1){1'b1}};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: every accepted task is owed one output, in order, no earlier
  // than L+1 cycles after its acceptance; credits outstanding = queue length.
  task_t q_task[$];
  int    q_cyc[$];
  int    cyc   = 0;
  int    n_acc = 0;
  int    n_pop = 0;
  int    m;
  logic  exp_ready, acc, exp_vld;

  function automatic task_t expect_of(input task_t t);
    task_t r;
    r              = t;
    r.head_ptr     = ht_mem[t.bucket][AW-1:0];
    r.head_ptr_val = ht_mem[t.bucket][AW];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q_task.delete();
      q_cyc.delete();
    end else begin
      cyc++;
      m         = q_task.size();
      exp_ready = (m < DEPTH);
      acc       = task_valid_i && exp_ready;
      exp_vld   = (m > 0) && (q_cyc[0] + L + 1 <= cyc);
      check("m_ready", task_ready_o, exp_ready);
      check("m_busy", busy_o, m != 0);
      check("m_rd_en", ht_rd_en_o, acc);
      check("m_rd_addr", ht_rd_addr_o, acc ? task_i.bucket : 8'h00);
      check("m_valid", task_valid_o, exp_vld);
      if (exp_vld) check("m_task_o", task_o, q_task[0]);
      if (exp_vld && task_ready_i) begin
        void'(q_task.pop_front());
        void'(q_cyc.pop_front());
        n_pop++;
      end
      if (acc) begin
        q_task.push_back(expect_of(task_i));
        q_cyc.push_back(cyc);
        n_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] key, input logic [7:0] bkt, input logic rdy);
    task_valid_i = v;
    task_i       = '{key: key, bucket: bkt, head_ptr: 8'hEE, head_ptr_val: 1'b1};
    task_ready_i = rdy;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && busy_o; i++) step();
  endtask

  int drops, a0, p0, stale;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) ht_mem[i] = 9'((i * 37 + 11) ^ (i << 3));
    ht_mem[8'h15] = 9'h12A;
    ht_mem[8'h33] = 9'h077;
    for (int i = 0; i < L; i++) d_en[i] = 1'b0;
    rst = 1'b1;
    drive(1'b0, 16'h0, 8'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", task_ready_o, 1);
    check("rst_valid", task_valid_o, 0);
    check("rst_task_o", task_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rd_en", ht_rd_en_o, 0);
    rst = 1'b0;

    // Single task: accept at N, output visible at N+3
    step(); drive(1'b1, 16'hBEEF, 8'h15, 1'b1); #1;
    check("single_rd_en", ht_rd_en_o, 1);
    check("single_addr", ht_rd_addr_o, 8'h15);
    step(); drive(1'b0, 16'h0, 8'h0, 1'b1);
    step(); #1;
    check("single_not_early", task_valid_o, 0);
    step(); #1;
    check("single_valid", task_valid_o, 1);
    check("single_head_ptr", task_o.head_ptr, 8'h2A);
    check("single_ptr_val", task_o.head_ptr_val, 1);
    check("single_key", task_o.key, 16'hBEEF);
    step(); #1;
    check("single_busy_after_pop", busy_o, 0);

    // Empty pointer
    step(); drive(1'b1, 16'h1234, 8'h33, 1'b1);
    step(); drive(1'b0, 16'h0, 8'h0, 1'b1);
    step(); step(); #1;
    check("empty_valid", task_valid_o, 1);
    check("empty_ptr_val", task_o.head_ptr_val, 0);
    check("empty_head_ptr", task_o.head_ptr, 8'h77);
    check("empty_key", task_o.key, 16'h1234);
    check("empty_bucket", task_o.bucket, 8'h33);
    step();

    // Streaming
    drops = 0;
    p0    = n_pop;
    for (int i = 0; i < 100; i++) begin
      step(); drive(1'b1, 16'(i), 8'(i * 13), 1'b1); #1;
      if (!task_ready_o) drops++;
    end
    step(); drive(1'b0, 16'h0, 8'h0, 1'b1);
    drain(30);
    step();
    check("stream_ready_drops", drops, 0);
    check("stream_out_count", n_pop - p0, 100);

    // Backpressure
    a0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      step(); drive(1'b1, 16'(16'h4000 + i), 8'(8'h80 + i), 1'b0);
    end
    #1;
    check("bp_ready_low", task_ready_o, 0);
    step(); drive(1'b0, 16'h0, 8'h0, 1'b0);
    check("bp_accepts", n_acc - a0, 4);
    p0 = n_pop;
    drive(1'b0, 16'h0, 8'h0, 1'b1);
    drain(30);
    step();
    check("bp_drained", n_pop - p0, 4);
    check("bp_idle", busy_o, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      drive(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 1'($urandom_range(0, 9) < 3));
    end
    step(); drive(1'b0, 16'h0, 8'h0, 1'b1);
    drain(40);
    step();
    check("rand_idle", busy_o, 0);
    check("rand_balance", n_acc, n_pop);

    // Reset with two tasks buffered and two reads in flight
    for (int i = 0; i < 4; i++) begin
      step(); drive(1'b1, 16'(16'h7000 + i), 8'(8'h40 + i), 1'b0);
    end
    step(); drive(1'b0, 16'h0, 8'h0, 1'b0);
    rst = 1'b1;
    #1;
    check("mrst_valid", task_valid_o, 0);
    check("mrst_task_o", task_o, 0);
    check("mrst_ready", task_ready_o, 1);
    check("mrst_busy", busy_o, 0);
    check("mrst_rd_en", ht_rd_en_o, 0);
    step(); rst = 1'b0; drive(1'b0, 16'h0, 8'h0, 1'b1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      if (task_valid_o) stale++;
    end
    check("mrst_no_stale", stale, 0);
    step(); drive(1'b1, 16'hCAFE, 8'h15, 1'b1);
    step(); drive(1'b0, 16'h0, 8'h0, 1'b1);
    step(); step(); #1;
    check("mrst_next_valid", task_valid_o, 1);
    check("mrst_next_ptr", task_o.head_ptr, 8'h2A);
    check("mrst_next_key", task_o.key, 16'hCAFE);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
